// File: rtl/conv_pkg.sv
// Shared parameters and types for the convolution input loader.
// Contents:
//   N, M, T        x depth, filter depth, data width
//   XADDR_W        x memory address width
//   FADDR_W        f memory address width
//   ld_state_t     loader FSM state (LOAD / RUN)
package conv_pkg;

  localparam int unsigned N       = 43;
  localparam int unsigned M       = 16;
  localparam int unsigned T       = 32;
  localparam int unsigned XADDR_W = $clog2(N);
  localparam int unsigned FADDR_W = $clog2(M);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } ld_state_t;

endpackage : conv_pkg

// File: rtl/load_counter.sv
// Saturating write-address counter for one loader memory.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear        return to empty (address 0, not full)
//   inc          one word accepted this cycle
//   cnt          current write address
//   full         all DEPTH words written
//   full_nxt     value full takes on the next edge (combinational)
// The address stays at DEPTH-1 once full. A separate full flag lets a
// power-of-two DEPTH fit in AW bits without an extra counter bit.
module load_counter #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [AW-1:0] cnt,
  output logic          full,
  output logic          full_nxt
);

  logic [AW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;

  // Next count: clear wins, then advance or set full on the last word
  always_comb begin
    cnt_d  = cnt_q;
    full_d = full_q;
    if (clear) begin
      cnt_d  = '0;
      full_d = 1'b0;
    end else if (inc && !full_q) begin
      if (cnt_q == AW'(DEPTH - 1)) begin
        full_d = 1'b1;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign cnt      = cnt_q;
  assign full     = full_q;
  assign full_nxt = full_d;

endmodule : load_counter

// File: rtl/conv_input_loader.sv
// Loads the x sample vector and the filter taps from two valid/ready streams
// into their memories, then raises conv_start and holds the memories until
// conv_done returns the loader to LOAD for the next vector.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   s_data_in_x/s_valid_x/s_ready_x   x input stream
//   s_data_in_f/s_valid_f/s_ready_f   filter input stream
//   conv_done                         pulse: convolution finished
//   conv_start                        both memories loaded (state == RUN)
//   x_wr_en/x_wr_addr/x_wr_data       x memory write port
//   f_wr_en/f_wr_addr/f_wr_data       f memory write port
// Build option: LOADER_FILTER_PERSIST_EN keeps the filter loaded across runs
// so only x is reloaded after conv_done; only reset empties the filter.
module conv_input_loader
  import conv_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [T-1:0]       s_data_in_x,
  input  logic               s_valid_x,
  output logic               s_ready_x,
  input  logic [T-1:0]       s_data_in_f,
  input  logic               s_valid_f,
  output logic               s_ready_f,
  input  logic               conv_done,
  output logic               conv_start,
  output logic               x_wr_en,
  output logic [XADDR_W-1:0] x_wr_addr,
  output logic [T-1:0]       x_wr_data,
  output logic               f_wr_en,
  output logic [FADDR_W-1:0] f_wr_addr,
  output logic [T-1:0]       f_wr_data
);

  ld_state_t state_q, state_d;

  logic [XADDR_W-1:0] x_cnt;
  logic [FADDR_W-1:0] f_cnt;
  logic x_full, x_full_nxt, f_full, f_full_nxt;
  logic x_clear, f_clear;
  logic x_acc, f_acc;
  logic run_exit;

  // Readies only in LOAD and only while the memory still has room
  assign s_ready_x = (state_q == LOAD) && !x_full;
  assign s_ready_f = (state_q == LOAD) && !f_full;

  assign x_acc = s_valid_x && s_ready_x;
  assign f_acc = s_valid_f && s_ready_f;

  assign run_exit = (state_q == RUN) && conv_done;
  assign x_clear  = run_exit;
`ifdef LOADER_FILTER_PERSIST_EN
  assign f_clear  = 1'b0;
`else
  assign f_clear  = run_exit;
`endif

  load_counter #(.DEPTH(N), .AW(XADDR_W)) u_x_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (x_clear),
    .inc      (x_acc),
    .cnt      (x_cnt),
    .full     (x_full),
    .full_nxt (x_full_nxt)
  );

  load_counter #(.DEPTH(M), .AW(FADDR_W)) u_f_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (f_clear),
    .inc      (f_acc),
    .cnt      (f_cnt),
    .full     (f_full),
    .full_nxt (f_full_nxt)
  );

  // Memory writes land on the same edge as the handshake
  assign x_wr_en   = x_acc;
  assign x_wr_addr = x_cnt;
  assign x_wr_data = s_data_in_x;
  assign f_wr_en   = f_acc;
  assign f_wr_addr = f_cnt;
  assign f_wr_data = s_data_in_f;

  // Next state: enter RUN on the edge both memories become full
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: if (x_full_nxt && f_full_nxt) state_d = RUN;
      RUN:  if (conv_done)                state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  assign conv_start = (state_q == RUN);

endmodule : conv_input_loader

// File: tb/tb_conv_input_loader.sv
module tb_conv_input_loader;
  import conv_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic [T-1:0]       s_data_in_x, s_data_in_f;
  logic               s_valid_x, s_valid_f, s_ready_x, s_ready_f;
  logic               conv_done, conv_start;
  logic               x_wr_en, f_wr_en;
  logic [XADDR_W-1:0] x_wr_addr;
  logic [FADDR_W-1:0] f_wr_addr;
  logic [T-1:0]       x_wr_data, f_wr_data;

  typedef struct {
    int unsigned addr;
    logic [T-1:0] data;
  } wr_exp_t;

  wr_exp_t xq[$];
  wr_exp_t fq[$];

  int checks = 0;
  int failures = 0;

  // Reference model of the loader
  int unsigned mx, mf;
  bit          mrun;

  conv_input_loader dut (
    .clk         (clk),
    .reset       (reset),
    .s_data_in_x (s_data_in_x),
    .s_valid_x   (s_valid_x),
    .s_ready_x   (s_ready_x),
    .s_data_in_f (s_data_in_f),
    .s_valid_f   (s_valid_f),
    .s_ready_f   (s_ready_f),
    .conv_done   (conv_done),
    .conv_start  (conv_start),
    .x_wr_en     (x_wr_en),
    .x_wr_addr   (x_wr_addr),
    .x_wr_data   (x_wr_data),
    .f_wr_en     (f_wr_en),
    .f_wr_addr   (f_wr_addr),
    .f_wr_data   (f_wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_valid_x = 1'b0; s_valid_f = 1'b0; conv_done = 1'b0;
    s_data_in_x = '0; s_data_in_f = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    mx = 0; mf = 0; mrun = 1'b0;
    xq.delete(); fq.delete();
  endtask

  // One clock: drive, check combinational outputs at negedge, advance model
  task automatic cycle(input bit vx, input bit vf, input bit done);
    bit ax, af;
    wr_exp_t e;
    s_valid_x   = vx;
    s_valid_f   = vf;
    conv_done   = done;
    s_data_in_x = T'($urandom);
    s_data_in_f = T'($urandom);
    ax = vx && !mrun && (mx < N);
    af = vf && !mrun && (mf < M);
    if (ax) begin e.addr = mx; e.data = s_data_in_x; xq.push_back(e); end
    if (af) begin e.addr = mf; e.data = s_data_in_f; fq.push_back(e); end
    @(negedge clk);
    check("s_ready_x", 64'(s_ready_x), 64'(!mrun && (mx < N)));
    check("s_ready_f", 64'(s_ready_f), 64'(!mrun && (mf < M)));
    check("conv_start", 64'(conv_start), 64'(mrun));
    check("x_wr_en", 64'(x_wr_en), 64'(ax));
    check("f_wr_en", 64'(f_wr_en), 64'(af));
    if (x_wr_en === 1'b1 && xq.size() > 0) begin
      e = xq.pop_front();
      check("x_wr_addr", 64'(x_wr_addr), 64'(e.addr));
      check("x_wr_data", 64'(x_wr_data), 64'(e.data));
    end
    if (f_wr_en === 1'b1 && fq.size() > 0) begin
      e = fq.pop_front();
      check("f_wr_addr", 64'(f_wr_addr), 64'(e.addr));
      check("f_wr_data", 64'(f_wr_data), 64'(e.data));
    end
    @(posedge clk); #1;
    if (!mrun) begin
      mx += 32'(ax);
      mf += 32'(af);
      if (mx == N && mf == M) mrun = 1'b1;
    end else if (done) begin
      mrun = 1'b0;
      mx = 0;
`ifndef LOADER_FILTER_PERSIST_EN
      mf = 0;
`endif
    end
  endtask

  initial begin
    reset = 1'b1;
    s_valid_x = 1'b0; s_valid_f = 1'b0; conv_done = 1'b0;
    s_data_in_x = '0; s_data_in_f = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_conv_start", 64'(conv_start), 64'(0));
    check("rst_ready_x", 64'(s_ready_x), 64'(1));
    check("rst_ready_f", 64'(s_ready_f), 64'(1));
    @(posedge clk); #1;

    // 1: back-to-back load of both streams
    for (int i = 0; i < N; i++) cycle(1'b1, i < M, 1'b0);
    check("t1_conv_start", 64'(conv_start), 64'(1));
    cycle(1'b0, 1'b0, 1'b1);

    // 2: f completes first, x stalls at 20 words
    for (int i = 0; i < 20; i++) cycle(1'b1, i < M, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0);
    check("t2_ready_f", 64'(s_ready_f), 64'(0));
    check("t2_conv_start", 64'(conv_start), 64'(0));
    for (int i = 20; i < N; i++) cycle(1'b1, 1'b1, 1'b0);

    // 3: valids in RUN are ignored, then conv_done returns to LOAD
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    check("t3_conv_start", 64'(conv_start), 64'(0));
    check("t3_ready_x", 64'(s_ready_x), 64'(1));

    // 4: last x and last f in the same cycle
    do_reset();
    for (int i = 0; i < N - 1; i++) cycle(1'b1, i < M - 1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("t4_conv_start", 64'(conv_start), 64'(1));
    cycle(1'b0, 1'b0, 1'b0);
    // conv_done in LOAD ignored afterwards is covered below

    // 5: reset mid-load discards partial data
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
    do_reset();
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) cycle(1'b1, i < M, 1'b0);
    check("t5_conv_start", 64'(conv_start), 64'(1));
    cycle(1'b0, 1'b0, 1'b1);

    // 6: reload after conv_done (filter kept when persistence is built in)
`ifdef LOADER_FILTER_PERSIST_EN
    check("t6_ready_f", 64'(s_ready_f), 64'(0));
    for (int i = 0; i < N; i++) cycle(1'b1, 1'b1, 1'b0);
`else
    check("t6_ready_f", 64'(s_ready_f), 64'(1));
    for (int i = 0; i < N; i++) cycle(1'b1, i < M, 1'b0);
`endif
    check("t6_conv_start", 64'(conv_start), 64'(1));
    cycle(1'b0, 1'b0, 1'b0);

    check("xq_drained", 64'(xq.size()), 64'(0));
    check("fq_drained", 64'(fq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_conv_input_loader
